// File: rtl/hack_bank_arbiter.sv
// Round-robin arbiter sharing one memory bank among 4 requesters.
// Registered one-hot grant plus select index, with bounded hold under contention.
module hack_bank_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;

  // First set bit of mask, scanning upward from base with wrap-around.
  function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] mask,
                                             input logic [IDX_W-1:0] base);
    logic [IDX_W-1:0] result;
    logic [IDX_W-1:0] idx;
    logic             found;
    result = base;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = base + IDX_W'(k);
      if (!found && mask[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] others;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] win;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    win        = '0;
    owner_mask = N_REQ'(1) << sel_q;
    others     = req & ~owner_mask;
    next_ptr   = sel_q + IDX_W'(1);

    case (state_q)
      IDLE: begin
        if (|req) begin
          win     = pick(req, ptr_q);
          gnt_d   = N_REQ'(1) << win;
          sel_d   = win;
          cnt_d   = CNT_ONE;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          // Owner released: hand over directly, or go idle keeping sel.
          ptr_d = next_ptr;
          if (|others) begin
            win   = pick(req, next_ptr);
            gnt_d = N_REQ'(1) << win;
            sel_d = win;
            cnt_d = CNT_ONE;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if ((cnt_q == HOLD_MAX) && (|others)) begin
          ptr_d = next_ptr;
          win   = pick(others, next_ptr);
          gnt_d = N_REQ'(1) << win;
          sel_d = win;
          cnt_d = CNT_ONE;
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= |gnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_hack_bank_arbiter.sv
// Testbench for hack_bank_arbiter: directed scenarios plus random traffic
// compared against an owner/pointer/hold-count reference model.
module tb_hack_bank_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference model: owner index (-1 when idle), scan start, cycles held.
  int m_owner = -1;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_hold  = 0;

  hack_bank_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_from(input logic [3:0] r, input int start, input int excl);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (start + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input bit rst);
    bit others;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      if (r != 4'b0000) begin
        m_owner = first_from(r, m_ptr, -1);
        m_hold  = 1;
      end
    end else begin
      others = (first_from(r, 0, m_owner) >= 0);
      if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = others ? first_from(r, m_ptr, -1) : -1;
        m_hold  = 1;
      end else if (m_hold >= MAX_HOLD && others) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = first_from(r, m_ptr, m_owner);
        m_hold  = 1;
      end else begin
        m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
      end
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs and invariants.
  task automatic step(input logic [3:0] r, input bit rst);
    logic [3:0] exp_gnt;
    req   = r;
    reset = rst;
    @(posedge clk);
    #1;
    model_step(r, rst);
    exp_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk("gnt", 8'(gnt), 8'(exp_gnt));
    chk("sel", 8'(sel), 8'(m_sel));
    chk("busy", 8'(busy), 8'(m_owner >= 0));
    chk("inv_onehot0", 8'($onehot0(gnt)), 8'd1);
    chk("inv_busy_or", 8'(busy), 8'(|gnt));
    if (busy) chk("inv_gnt_sel", 8'(gnt[sel]), 8'd1);
    if (!rst) chk("inv_req_prev", 8'(gnt & ~r), 8'd0);
    #3;
  endtask

  logic [3:0] rr;

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    #2;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("reset_gnt", 8'(gnt), 8'h0);
    chk("reset_sel", 8'(sel), 8'h0);
    chk("reset_busy", 8'(busy), 8'h0);

    // Single request, then drop
    step(4'b0001, 1'b0);
    chk("tp1_gnt", 8'(gnt), 8'h1);
    chk("tp1_busy", 8'(busy), 8'h1);
    step(4'b0000, 1'b0);
    chk("tp1_idle_gnt", 8'(gnt), 8'h0);
    chk("tp1_idle_sel", 8'(sel), 8'h0);

    // Full contention rotates every MAX_HOLD cycles with no bubbles
    step(4'b0000, 1'b1);
    for (int k = 0; k <= 32; k++) begin
      step(4'b1111, 1'b0);
      rr = 4'b0001;
      rr = rr << ((k / MAX_HOLD) % 4);
      chk("tp2_rotate", 8'(gnt), 8'(rr));
    end

    // Release hands over directly, then idle leaves ptr at 3
    step(4'b0000, 1'b1);
    step(4'b0110, 1'b0);
    chk("tp3_own1", 8'(gnt), 8'h2);
    step(4'b0100, 1'b0);
    chk("tp3_handover", 8'(gnt), 8'h4);
    chk("tp3_sel", 8'(sel), 8'h2);
    step(4'b0000, 1'b0);
    chk("tp3_idle", 8'(gnt), 8'h0);
    chk("tp3_sel_hold", 8'(sel), 8'h2);

    // Scan order 3,0,1,2
    step(4'b0101, 1'b0);
    chk("tp4_wrap", 8'(gnt), 8'h1);

    // Lone requester never preempted, then immediate preempt at saturated count
    for (int k = 0; k < 20; k++) begin
      step(4'b1000, 1'b0);
      chk("tp5_lone", 8'(gnt), 8'h8);
    end
    step(4'b1001, 1'b0);
    chk("tp5_preempt", 8'(gnt), 8'h1);

    // Mid-grant reset clears ptr
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b1111, 1'b0);
    chk("tp6_pre", 8'(gnt), 8'h4);
    step(4'b1111, 1'b1);
    chk("tp6_rst", 8'(gnt), 8'h0);
    chk("tp6_rst_sel", 8'(sel), 8'h0);
    step(4'b1111, 1'b0);
    chk("tp6_after", 8'(gnt), 8'h1);

    // Random traffic with sticky requests so holds and preempts occur
    rr = 4'b0000;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
      step(rr, ($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
